decoder_seq: RTL and testbench
==============================

DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 Parameter N, default 2: address width; output width is M = 2**N.
REQ-002 Parameter LAST, default 2**N-1: terminal state of SEQ mode; legal range 0..M-1.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  enable; when low, outputs are forced to zero and state holds.
REQ-006 mode  input  2  operating mode: 00 DIRECT, 01 PULSE, 10 SEQ, 11 reserved.
REQ-007 addr  input  N  select / SEQ start index.
REQ-008 load  input  1  PULSE trigger / SEQ pointer load strobe.
REQ-009 step  input  1  SEQ advance strobe.
REQ-010 y  output  M  registered one-hot (or all-zero) decode.
REQ-011 wrap  output  1  one-cycle pulse on SEQ terminal wrap.
REQ-012 err  output  1  one-cycle pulse on an illegal SEQ load.

Function
REQ-013 All outputs SHALL be registered; every response appears the cycle after the sampling edge (latency 1).
REQ-014 en=0: next y SHALL be 0, wrap=0 and err=0; ptr SHALL hold; load and step SHALL be ignored.
REQ-015 DIRECT (en=1): next y SHALL be onehot(addr); load and step SHALL be ignored; ptr SHALL hold.
REQ-016 PULSE (en=1): load=1 SHALL give y=onehot(addr) for exactly one cycle; load=0 SHALL give y=0; back-to-back loads SHALL give consecutive one-cycle pulses, each tracking the addr sampled with it.
REQ-017 SEQ (en=1): y SHALL equal onehot(ptr) every cycle the mode is SEQ.
REQ-018 SEQ load=1 with addr<=LAST: ptr SHALL become addr.
REQ-019 SEQ load=1 with addr>LAST: ptr SHALL become 0 and err SHALL pulse for one cycle.
REQ-020 SEQ load=0 and step=1: ptr SHALL become ptr+1 when ptr<LAST; when ptr=LAST, ptr SHALL become 0 and wrap SHALL pulse for one cycle.
REQ-021 load and step asserted together: load SHALL win; step is dropped; no wrap is generated.
REQ-022 load=0 and step=0 in SEQ: ptr SHALL hold.
REQ-023 LAST=0: every step SHALL produce wrap, and ptr SHALL remain 0.
REQ-024 mode=11: y SHALL be 0, wrap and err SHALL be 0, and ptr SHALL hold.
REQ-025 Mode change: ptr SHALL be preserved across mode changes, so a later return to SEQ resumes at the held ptr.
REQ-026 y SHALL never have more than one bit set.

Reset
REQ-027 rst=1 SHALL set ptr=0, y=0, wrap=0 and err=0 at the next edge, regardless of en, mode, load or step.
REQ-028 rst asserted mid-sequence SHALL abort the sequence; the first SEQ cycle after release SHALL show y=onehot(0).

Structure
REQ-029 Mode encodings (DIRECT, PULSE, SEQ, RSVD) SHALL be defined as constants in the shared CPU definitions package.
REQ-030 A combinational sub-module onehot_dec (N in, 2**N out) SHALL perform the index-to-one-hot conversion and be instantiated once, its input muxed between addr and ptr.
REQ-031 Sequential state SHALL be limited to ptr, y, wrap and err.
REQ-032 Parameter legality (LAST<M) SHALL be checked at elaboration.

Verification
REQ-033 Reset, then N=2, en=1, DIRECT, addr=00,01,10,11 -> y=0001,0010,0100,1000 one cycle after each; en=0 -> y=0000.
REQ-034 PULSE, load pulsed once with addr=10 -> y=0100 for exactly one cycle, then 0000; two consecutive loads with 01 then 11 -> y=0010 then 1000.
REQ-035 LAST=2, SEQ, load addr=01, then step x3 -> y=0010,0100,0001,0010; wrap high only on the 0100->0001 transition.
REQ-036 LAST=2, SEQ, load addr=11 -> y=0001 and err=1 for one cycle; load+step same cycle with addr=01 -> y=0010, no wrap.
REQ-037 SEQ at ptr=2, assert rst for one cycle while step=1 -> y=0000; after release y=0001; then switch to DIRECT and back to SEQ -> ptr preserved.
REQ-038 N=3 regression: SEQ stepping through all 8 states -> each y one-hot, with wrap once per 8 steps.

Source files
------------

// File: rtl/decoder_seq_pkg.sv
// Shared definitions for decoder_seq: operating-mode encodings.
package decoder_seq_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_PULSE  = 2'b01,
    MODE_SEQ    = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

endpackage

// File: rtl/decoder_seq_onehot_dec.sv
// Combinational index-to-one-hot converter (N-bit index, 2**N-bit output).
module onehot_dec #(
  parameter int N = 2
) (
  input  logic [N-1:0]      idx,
  output logic [2**N-1:0]   dec
);

  // NOTE: assigning a default before the indexed write keeps every bit driven on every path, so no latch is inferred.
  always_comb begin
    dec      = '0;
    dec[idx] = 1'b1;
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered decoder with DIRECT, PULSE and SEQ (stepping pointer) modes;
// one shared one-hot converter fed from either addr or the next pointer.
module decoder_seq
  import decoder_seq_pkg::*;
#(
  parameter int N    = 2,
  parameter int LAST = 2**N - 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [N-1:0]    addr,
  input  logic            load,
  input  logic            step,
  output logic [2**N-1:0] y,
  output logic            wrap,
  output logic            err
);

  localparam int M = 2**N;

  if (LAST < 0 || LAST >= M) begin : g_bad_last
    $error("decoder_seq: LAST must lie in 0..2**N-1");
  end

  localparam logic [N-1:0] LAST_IDX = N'(LAST);

  mode_e          mode_s;
  logic [N-1:0]   ptr_q, ptr_d;
  logic [M-1:0]   y_q, y_d;
  logic           wrap_q, wrap_d;
  logic           err_q, err_d;
  logic [N-1:0]   sel_idx;
  logic [M-1:0]   dec_out;

  assign mode_s = mode_e'(mode);

  // Pointer update; the SEQ-mode display follows the pointer value being loaded.
  always_comb begin
    ptr_d  = ptr_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (en && mode_s == MODE_SEQ) begin
      if (load) begin
        if (addr > LAST_IDX) begin
          ptr_d = '0;
          err_d = 1'b1;
        end else begin
          ptr_d = addr;
        end
      end else if (step) begin
        if (ptr_q == LAST_IDX) begin
          ptr_d  = '0;
          wrap_d = 1'b1;
        end else begin
          ptr_d = ptr_q + N'(1);
        end
      end
    end
  end

  assign sel_idx = (mode_s == MODE_SEQ) ? ptr_d : addr;

  onehot_dec #(.N(N)) u_dec (
    .idx (sel_idx),
    .dec (dec_out)
  );

  always_comb begin
    y_d = '0;
    if (en) begin
      case (mode_s)
        MODE_DIRECT: y_d = dec_out;
        MODE_PULSE:  if (load) y_d = dec_out;
        MODE_SEQ:    y_d = dec_out;
        default:     y_d = '0;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      y_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      y_q    <= y_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign y    = y_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench: three decoder_seq variants share one stimulus stream and
// are compared against a behavioural model of the mode rules.
module tb_decoder_seq;

  logic       clk = 1'b0;
  logic       rst, en, load, step;
  logic [1:0] mode;
  logic [2:0] addr;

  logic [3:0] y_a, y_z;
  logic [7:0] y_b;
  logic       wrap_a, err_a, wrap_z, err_z, wrap_b, err_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // a: N=2 LAST=2, z: N=2 LAST=0, b: N=3 LAST default (7)
  decoder_seq #(.N(2), .LAST(2)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .addr(addr[1:0]),
    .load(load), .step(step), .y(y_a), .wrap(wrap_a), .err(err_a));

  decoder_seq #(.N(2), .LAST(0)) u_dut_z (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .addr(addr[1:0]),
    .load(load), .step(step), .y(y_z), .wrap(wrap_z), .err(err_z));

  decoder_seq #(.N(3)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .addr(addr),
    .load(load), .step(step), .y(y_b), .wrap(wrap_b), .err(err_b));

  typedef struct packed {
    logic [2:0][7:0] y;
    logic [2:0]      wrap;
    logic [2:0]      err;
  } exp_t;

  exp_t exp_q[$];
  int   ptr_m[3];
  int   n_of[3]    = '{2, 2, 3};
  int   last_of[3] = '{2, 0, 7};

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural rules: y is 1<<index, pointer is a plain integer.
  function automatic void model(input int n, input int last, input bit r, input bit e,
                                input int md, input int a_full, input bit ld, input bit st,
                                inout int ptr, output int y, output bit w, output bit er);
    int a;
    a  = a_full % (1 << n);
    y  = 0;
    w  = 0;
    er = 0;
    if (r) begin
      ptr = 0;
      return;
    end
    if (!e) return;
    case (md)
      0: y = 1 << a;
      1: y = ld ? (1 << a) : 0;
      2: begin
        if (ld) begin
          if (a > last) begin ptr = 0; er = 1; end
          else ptr = a;
        end else if (st) begin
          if (ptr == last) begin ptr = 0; w = 1; end
          else ptr = ptr + 1;
        end
        y = 1 << ptr;
      end
      default: ;
    endcase
  endfunction

  task automatic cyc(input bit r, input bit e, input int md, input int a,
                     input bit ld, input bit st);
    exp_t ex;
    int   yv;
    bit   wv, ev;
    rst  = r;
    en   = e;
    mode = 2'(md);
    addr = 3'(a);
    load = ld;
    step = st;
    for (int k = 0; k < 3; k++) begin
      model(n_of[k], last_of[k], r, e, md, a, ld, st, ptr_m[k], yv, wv, ev);
      ex.y[k]    = 8'(yv);
      ex.wrap[k] = wv;
      ex.err[k]  = ev;
    end
    exp_q.push_back(ex);
    @(negedge clk);
  endtask

  // Monitor: outputs are valid every cycle; compare one entry per clock.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        check("y_a",    int'(y_a),    int'(ex.y[0]));
        check("wrap_a", int'(wrap_a), int'(ex.wrap[0]));
        check("err_a",  int'(err_a),  int'(ex.err[0]));
        check("y_z",    int'(y_z),    int'(ex.y[1]));
        check("wrap_z", int'(wrap_z), int'(ex.wrap[1]));
        check("err_z",  int'(err_z),  int'(ex.err[1]));
        check("y_b",    int'(y_b),    int'(ex.y[2]));
        check("wrap_b", int'(wrap_b), int'(ex.wrap[2]));
        check("err_b",  int'(err_b),  int'(ex.err[2]));
        check("onehot_b", int'($countones(y_b) <= 1), 1);
      end
    end
  end

  initial begin
    int wraps_b;
    // reset and DIRECT sweep, then en=0
    cyc(1, 0, 0, 0, 0, 0);
    for (int a = 0; a < 4; a++) cyc(0, 1, 0, a, 0, 0);
    cyc(0, 0, 0, 3, 1, 1);
    // PULSE: single pulse, idle, back-to-back pulses
    cyc(0, 1, 1, 2, 1, 0);
    cyc(0, 1, 1, 2, 0, 0);
    cyc(0, 1, 1, 1, 1, 0);
    cyc(0, 1, 1, 3, 1, 0);
    cyc(0, 1, 1, 3, 0, 0);
    // SEQ: load 1, three steps
    cyc(0, 1, 2, 1, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 2, 0, 0, 1);
    // illegal load, load+step together
    cyc(0, 1, 2, 3, 1, 0);
    cyc(0, 1, 2, 1, 1, 1);
    // step to ptr=2, then reset with step high, idle, mode round trip
    cyc(0, 1, 2, 0, 0, 1);
    cyc(1, 1, 2, 0, 0, 1);
    cyc(0, 1, 2, 0, 0, 0);
    cyc(0, 1, 2, 0, 0, 1);
    cyc(0, 1, 0, 2, 0, 0);
    cyc(0, 1, 3, 2, 1, 1);
    cyc(0, 1, 2, 0, 0, 0);
    // full 8-state walk on the N=3 instance
    cyc(0, 1, 2, 0, 1, 0);
    wraps_b = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 2, 0, 0, 1);
      if (ptr_m[2] == 0) wraps_b++;
    end
    check("model_wraps_b", wraps_b, 2);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
          ($urandom_range(0, 9) < 3), ($urandom_range(0, 1) == 1));
    end
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
